packet_transmitter: RTL and testbench

- Builds and sends the 5-byte validated packet consumed by the board's packet receiver: HDR0, HDR1, DATA1, DATA2, CRC, where CRC = DATA1 ^ DATA2.
- Each byte is presented on a parallel 8-bit bus. A strobe (transmission_start) rises once per byte while the bus is stable, so the receiver captures the byte on the strobe's rising edge.
- Sits between the user-side data source (switches/registers) and the inter-board byte link.

---
 rtl/pkt_pkg.sv | 26 ++
 rtl/packet_transmitter_if.sv | 23 ++
 rtl/packet_transmitter.sv | 138 +++++++++++++
 tb/tb_packet_transmitter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_pkg.sv
// Constants, CRC helper and state encoding shared by the packet transmitter and receiver.
package pkt_pkg;

    localparam int         PKT_LEN  = 5;
    localparam logic [7:0] HDR0_DEF = 8'hAA;
    localparam logic [7:0] HDR1_DEF = 8'h55;

    localparam logic [2:0] IDX_H0  = 3'd0;
    localparam logic [2:0] IDX_H1  = 3'd1;
    localparam logic [2:0] IDX_D1  = 3'd2;
    localparam logic [2:0] IDX_D2  = 3'd3;
    localparam logic [2:0] IDX_CRC = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_GAP,
        ST_DONE
    } tx_state_e;

    function automatic logic [7:0] xor_crc(input logic [7:0] a, input logic [7:0] b);
        return a ^ b;
    endfunction

endpackage

// File: rtl/packet_transmitter_if.sv
// User-side request/payload signals and the byte link toward the receiver.
interface packet_transmitter_if;

    logic       send;
    logic [7:0] DATA1;
    logic [7:0] DATA2;
    logic       ready;
    logic       busy;
    logic [7:0] BYTE_output;
    logic       transmission_start;
    logic       done;

    modport master (
        input  send, DATA1, DATA2,
        output ready, busy, BYTE_output, transmission_start, done
    );

    modport slave (
        output send, DATA1, DATA2,
        input  ready, busy, BYTE_output, transmission_start, done
    );

endinterface

// File: rtl/packet_transmitter.sv
// Sends HDR0, HDR1, DATA1, DATA2, CRC as strobed parallel bytes; one FSM plus one down-counter.
module packet_transmitter
    import pkt_pkg::*;
#(
    parameter logic [7:0] HDR0       = HDR0_DEF,
    parameter logic [7:0] HDR1       = HDR1_DEF,
    parameter int         STROBE_LEN = 2,
    parameter int         GAP_LEN    = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    packet_transmitter_if.master  bus
);

    localparam int CNT_MAX = ((STROBE_LEN > GAP_LEN) ? STROBE_LEN : GAP_LEN) - 1;
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    tx_state_e        state, state_n;
    logic [2:0]       idx, idx_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [7:0]       byte_q, byte_n;
    logic             strobe_q, strobe_n;
    logic             done_q, done_n;
    logic             busy_q, busy_n;
    logic             ready_q, ready_n;
    logic             latch;
    logic [7:0]       d1_q, d2_q, crc_q;

    function automatic logic [7:0] sel_byte(input logic [2:0] i, input logic [7:0] d1,
                                            input logic [7:0] d2, input logic [7:0] crc);
        case (i)
            IDX_H0:  return HDR0;
            IDX_H1:  return HDR1;
            IDX_D1:  return d1;
            IDX_D2:  return d2;
            default: return crc;
        endcase
    endfunction

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        cnt_n    = cnt;
        byte_n   = byte_q;
        strobe_n = strobe_q;
        done_n   = done_q;
        busy_n   = busy_q;
        ready_n  = ready_q;
        latch    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.send) begin
                    latch   = 1'b1;
                    idx_n   = IDX_H0;
                    byte_n  = HDR0;
                    ready_n = 1'b0;
                    busy_n  = 1'b1;
                    state_n = ST_SETUP;
                end
            end
            // The byte has been on the bus for one cycle before the strobe rises.
            ST_SETUP: begin
                strobe_n = 1'b1;
                cnt_n    = STROBE_LOAD;
                state_n  = ST_STROBE;
            end
            ST_STROBE: begin
                if (cnt == '0) begin
                    strobe_n = 1'b0;
                    cnt_n    = GAP_LOAD;
                    state_n  = ST_GAP;
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CNT_ONE;
                end else if (idx == IDX_CRC) begin
                    done_n  = 1'b1;
                    state_n = ST_DONE;
                end else begin
                    idx_n   = idx + 3'd1;
                    byte_n  = sel_byte(idx + 3'd1, d1_q, d2_q, crc_q);
                    state_n = ST_SETUP;
                end
            end
            ST_DONE: begin
                done_n  = 1'b0;
                busy_n  = 1'b0;
                ready_n = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            idx      <= '0;
            cnt      <= '0;
            byte_q   <= 8'h00;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            cnt      <= cnt_n;
            byte_q   <= byte_n;
            strobe_q <= strobe_n;
            done_q   <= done_n;
            busy_q   <= busy_n;
            ready_q  <= ready_n;
        end
    end

    // Payload snapshot: later changes on DATA1/DATA2 cannot disturb a packet in flight.
    always_ff @(posedge CLK) begin
        if (latch) begin
            d1_q  <= bus.DATA1;
            d2_q  <= bus.DATA2;
            crc_q <= xor_crc(bus.DATA1, bus.DATA2);
        end
    end

    assign bus.ready              = ready_q;
    assign bus.busy               = busy_q;
    assign bus.BYTE_output        = byte_q;
    assign bus.transmission_start = strobe_q;
    assign bus.done               = done_q;

endmodule

// File: tb/tb_packet_transmitter.sv
// Bench for packet_transmitter: timeline model checked every cycle on two parameterisations.
module tb_packet_transmitter;
    import pkt_pkg::*;

    localparam int P = 5;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       send = 1'b0;
    logic [7:0] d1 = 8'h00;
    logic [7:0] d2 = 8'h00;

    packet_transmitter_if bus0();
    packet_transmitter_if bus1();

    packet_transmitter #(.HDR0(8'hAA), .HDR1(8'h55), .STROBE_LEN(2), .GAP_LEN(2))
        dut0 (.CLK(CLK), .RST_N(RST_N), .bus(bus0));
    packet_transmitter #(.HDR0(8'hAA), .HDR1(8'h55), .STROBE_LEN(1), .GAP_LEN(3))
        dut1 (.CLK(CLK), .RST_N(RST_N), .bus(bus1));

    always #5 CLK = ~CLK;

    assign bus0.send  = send;
    assign bus0.DATA1 = d1;
    assign bus0.DATA2 = d2;
    assign bus1.send  = send;
    assign bus1.DATA1 = d1;
    assign bus1.DATA2 = d2;

    logic [7:0] o_byte [2];
    logic       o_rdy  [2];
    logic       o_busy [2];
    logic       o_stb  [2];
    logic       o_done [2];
    assign o_byte[0] = bus0.BYTE_output;
    assign o_rdy[0]  = bus0.ready;
    assign o_busy[0] = bus0.busy;
    assign o_stb[0]  = bus0.transmission_start;
    assign o_done[0] = bus0.done;
    assign o_byte[1] = bus1.BYTE_output;
    assign o_rdy[1]  = bus1.ready;
    assign o_busy[1] = bus1.busy;
    assign o_stb[1]  = bus1.transmission_start;
    assign o_done[1] = bus1.done;

    int n_chk = 0;
    int n_err = 0;

    function automatic void chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Timeline model: one accepted packet at cycle acc, outputs follow from the byte period.
    int         cyc = 0;
    bit         act = 1'b0;
    int         acc = 0;
    logic [7:0] pkt [5];
    logic       e_rdy = 1'b1;
    logic       e_busy, e_done;
    logic [7:0] e_byte;
    logic       e_stb [2];

    function automatic void model_eval();
        int r, k, sl;
        e_rdy = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_byte = 8'h00;
        e_stb[0] = 1'b0; e_stb[1] = 1'b0;
        if (act) begin
            r = cyc - acc;
            if (r > 5 * P) begin
                e_byte = pkt[4];
            end else begin
                e_rdy  = 1'b0;
                e_busy = 1'b1;
                e_done = (r == 5 * P);
                k = r / P;
                if (k > 4) k = 4;
                e_byte = pkt[k];
                for (int i = 0; i < 2; i++) begin
                    sl = (i == 0) ? 2 : 1;
                    e_stb[i] = (r < 5 * P) && (r % P >= 1) && (r % P <= sl);
                end
            end
        end
    endfunction

    // Observations fed to the literal checks and the receiver model.
    logic [7:0] cap0[$], cap1[$];
    int rise0[$], busy_rise[$], done_rise[$], rdy_rise[$];
    int stb_hi [2];

    initial begin
        logic p_stb [2];
        logic p_busy, p_done, p_rdy;
        p_stb[0] = 1'b0; p_stb[1] = 1'b0;
        p_busy = 1'b0; p_done = 1'b0; p_rdy = 1'b1;
        stb_hi[0] = 0; stb_hi[1] = 0;
        forever begin
            @(posedge CLK);
            cyc++;
            if (!RST_N) begin
                act = 1'b0;
            end else if (e_rdy && send) begin
                act = 1'b1;
                acc = cyc;
                pkt[0] = 8'hAA; pkt[1] = 8'h55; pkt[2] = d1; pkt[3] = d2; pkt[4] = d1 ^ d2;
            end
            @(negedge CLK);
            if (!RST_N) act = 1'b0;
            model_eval();
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("ready[%0d]", i), o_rdy[i],  e_rdy);
                chk($sformatf("busy[%0d]", i),  o_busy[i], e_busy);
                chk($sformatf("done[%0d]", i),  o_done[i], e_done);
                chk($sformatf("byte[%0d]", i),  o_byte[i], e_byte);
                chk($sformatf("strobe[%0d]", i), o_stb[i], e_stb[i]);
                if (o_stb[i]) stb_hi[i]++;
                if (o_stb[i] && !p_stb[i]) begin
                    if (i == 0) begin
                        cap0.push_back(o_byte[0]);
                        rise0.push_back(cyc);
                    end else begin
                        cap1.push_back(o_byte[1]);
                    end
                end
                p_stb[i] = o_stb[i];
            end
            if (o_busy[0] && !p_busy) busy_rise.push_back(cyc);
            if (o_done[0] && !p_done) done_rise.push_back(cyc);
            if (o_rdy[0] && !p_rdy)   rdy_rise.push_back(cyc);
            p_busy = o_busy[0]; p_done = o_done[0]; p_rdy = o_rdy[0];
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic clear_obs();
        cap0.delete(); cap1.delete(); rise0.delete();
        busy_rise.delete(); done_rise.delete(); rdy_rise.delete();
        stb_hi[0] = 0; stb_hi[1] = 0;
    endtask

    task automatic start(input logic [7:0] a, input logic [7:0] b, output int e0);
        send = 1'b1; d1 = a; d2 = b;
        tick();
        e0 = cyc;
        send = 1'b0;
    endtask

    task automatic run_to(input int c);
        int n = 0;
        while (cyc < c && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(o_rdy[0] && o_rdy[1]) && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_idle_timeout"}, int'(o_rdy[0] && o_rdy[1]), 1);
        tick();
    endtask

    function automatic void chk_pkt(string tag, logic [7:0] b0, logic [7:0] b1,
                                    logic [7:0] b2, logic [7:0] b3, logic [7:0] b4);
        logic [7:0] exp [5];
        exp[0] = b0; exp[1] = b1; exp[2] = b2; exp[3] = b3; exp[4] = b4;
        chk({tag, "_count0"}, cap0.size(), 5);
        chk({tag, "_count1"}, cap1.size(), 5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("%s_byte0_%0d", tag, k), (k < cap0.size()) ? int'(cap0[k]) : -1, exp[k]);
            chk($sformatf("%s_byte1_%0d", tag, k), (k < cap1.size()) ? int'(cap1[k]) : -1, exp[k]);
        end
    endfunction

    // Receiver side of the loop: header match and XOR check on the captured frame.
    task automatic rx_check(output bit valid, output logic [7:0] r1, output logic [7:0] r2);
        valid = 1'b0; r1 = 8'h00; r2 = 8'h00;
        if (cap0.size() == PKT_LEN) begin
            if (cap0[0] == HDR0_DEF && cap0[1] == HDR1_DEF && cap0[4] == xor_crc(cap0[2], cap0[3])) begin
                valid = 1'b1; r1 = cap0[2]; r2 = cap0[3];
            end
        end
    endtask

    initial begin
        int e0;
        bit v;
        logic [7:0] r1, r2;

        // Reset state
        repeat (3) tick();
        chk("rst_ready", o_rdy[0], 1);
        chk("rst_busy", o_busy[0], 0);
        chk("rst_byte", o_byte[0], 8'h00);
        chk("rst_strobe", o_stb[0], 0);
        chk("rst_done", o_done[0], 0);
        RST_N = 1'b1;
        repeat (2) tick();
        clear_obs();

        // Basic packet, plus a send pulse while busy that must be ignored
        start(8'h3C, 8'hA5, e0);
        run_to(e0 + 6);
        send = 1'b1; d1 = 8'h11; d2 = 8'h22;
        tick();
        send = 1'b0;
        wait_idle("t1");
        chk_pkt("t1", 8'hAA, 8'h55, 8'h3C, 8'hA5, 8'h99);
        chk("t1_accepts", busy_rise.size(), 1);
        chk("t1_done_cyc", (done_rise.size() > 0) ? done_rise[0] - e0 : -1, 25);
        chk("t1_ready_cyc", (rdy_rise.size() > 0) ? rdy_rise[0] - e0 : -1, 26);
        for (int k = 0; k < 5; k++)
            chk($sformatf("t1_rise_%0d", k), (k < rise0.size()) ? rise0[k] - e0 : -1, 1 + 5 * k);
        chk("t1_strobe_cycles0", stb_hi[0], 10);
        chk("t1_strobe_cycles1", stb_hi[1], 5);
        clear_obs();

        // All-ones payload gives a zero CRC; receiver accepts it
        start(8'hFF, 8'hFF, e0);
        wait_idle("t2");
        chk_pkt("t2", 8'hAA, 8'h55, 8'hFF, 8'hFF, 8'h00);
        rx_check(v, r1, r2);
        chk("t2_rx_valid", v, 1);
        chk("t2_rx_d1", r1, 8'hFF);
        chk("t2_rx_d2", r2, 8'hFF);
        clear_obs();

        // send held high: back-to-back packets separated by the ready cycle
        send = 1'b1; d1 = 8'h5A; d2 = 8'hC3;
        tick();
        e0 = cyc;
        run_to(e0 + 10);
        d1 = 8'h77;
        run_to(e0 + 27);
        send = 1'b0;
        wait_idle("t4");
        chk("t4_strobes", rise0.size(), 10);
        chk("t4_accepts", busy_rise.size(), 2);
        chk("t4_second_accept", (busy_rise.size() > 1) ? busy_rise[1] - e0 : -1, 27);
        chk("t4_second_rise", (rise0.size() > 5) ? rise0[5] - e0 : -1, 28);
        chk("t4_p1_d1", (cap0.size() > 2) ? int'(cap0[2]) : -1, 8'h5A);
        chk("t4_p2_d1", (cap0.size() > 7) ? int'(cap0[7]) : -1, 8'h77);
        chk("t4_p2_crc", (cap0.size() > 9) ? int'(cap0[9]) : -1, 8'hB4);
        clear_obs();

        // Reset during the DATA1 strobe abandons the packet
        start(8'h12, 8'h34, e0);
        run_to(e0 + 11);
        chk("t5_pre_strobe", o_stb[0], 1);
        RST_N = 1'b0;
        #1;
        chk("t5_rst_strobe", o_stb[0], 0);
        chk("t5_rst_byte", o_byte[0], 8'h00);
        chk("t5_rst_busy", o_busy[0], 0);
        chk("t5_rst_done", o_done[0], 0);
        chk("t5_rst_ready", o_rdy[0], 1);
        repeat (2) tick();
        RST_N = 1'b1;
        tick();
        chk("t5_rel_ready", o_rdy[0], 1);
        clear_obs();
        start(8'h12, 8'h34, e0);
        wait_idle("t5");
        chk_pkt("t5", 8'hAA, 8'h55, 8'h12, 8'h34, 8'h26);
        rx_check(v, r1, r2);
        chk("t5_rx_valid", v, 1);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
